// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the ALU result channel and the load result channel onto
// the single register-bank write port. Each channel is buffered by a 2-entry
// FIFO; one head is written per cycle, round-robin under contention.
// Widths come from `WIDTH (data) and `REG_SEL (register select), normally
// supplied by defines.vh; fallback values are provided so the file stands alone.
// Optional feature: define WB_ARBITER_BYPASS_EN to let a transfer that arrives
// at an empty FIFO and wins arbitration go straight to the write port
// (latency 1 instead of 2). Arbitration order is the same either way.

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_SEL
`define REG_SEL 5
`endif

// Two-entry FIFO of {addr, data}. Push while full is legal only together with
// a pop; the write then lands in the slot being read out this cycle.
module wb_arbiter_fifo #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o
);
  logic [AW-1:0] addr_q [2];
  logic [DW-1:0] data_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  // Next pointers and occupancy; simultaneous push and pop keeps the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + 2'd1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 2'd1;
  end

  // Entry storage; contents are meaningless while empty, so no reset
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= addr_i;
      data_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full_o      = (cnt_q == 2'd2);
  assign empty_o     = (cnt_q == 2'd0);
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
endmodule

module wb_arbiter (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [`REG_SEL-1:0] alu_addr,
  input  logic [`WIDTH-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [`REG_SEL-1:0] mem_addr,
  input  logic [`WIDTH-1:0]   mem_data,
  output logic                write_enable,
  output logic [`REG_SEL-1:0] addr_z,
  output logic [`WIDTH-1:0]   data_z
);
  localparam int AW = `REG_SEL;
  localparam int DW = `WIDTH;

  typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_e;

  grant_e        last_q;
  logic          we_q;
  logic [AW-1:0] addr_z_q;
  logic [DW-1:0] data_z_q;

  logic          alu_full, alu_empty, mem_full, mem_empty;
  logic [AW-1:0] alu_head_addr, mem_head_addr;
  logic [DW-1:0] alu_head_data, mem_head_data;
  logic          alu_cand, mem_cand;
  logic          alu_gnt, mem_gnt;
  logic          alu_pop, mem_pop;
  logic          alu_byp, mem_byp;
  logic          alu_push, mem_push;
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;

  // Ready is simply "not full", forced low during reset.
  assign alu_ready = ~reset & ~alu_full;
  assign mem_ready = ~reset & ~mem_full;

`ifdef WB_ARBITER_BYPASS_EN
  // An incoming transfer competes as if it were already at the head.
  assign alu_cand = ~alu_empty | (alu_valid & alu_ready);
  assign mem_cand = ~mem_empty | (mem_valid & mem_ready);
`else
  assign alu_cand = ~alu_empty;
  assign mem_cand = ~mem_empty;
`endif

  // Round-robin grant, pop/bypass decode and write-port source selection
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (alu_cand && mem_cand) begin
      mem_gnt = (last_q == GNT_ALU);
      alu_gnt = (last_q == GNT_MEM);
    end else begin
      alu_gnt = alu_cand;
      mem_gnt = mem_cand;
    end

    alu_pop = alu_gnt & ~alu_empty;
    mem_pop = mem_gnt & ~mem_empty;
    alu_byp = alu_gnt & alu_empty;
    mem_byp = mem_gnt & mem_empty;

    // A full FIFO still takes a new entry when its head leaves this cycle.
    alu_push = alu_valid & ~reset & (~alu_full | alu_pop) & ~alu_byp;
    mem_push = mem_valid & ~reset & (~mem_full | mem_pop) & ~mem_byp;

    wr_en_d   = alu_gnt | mem_gnt;
    wr_addr_d = addr_z_q;
    wr_data_d = data_z_q;
    if (mem_gnt) begin
      wr_addr_d = mem_byp ? mem_addr : mem_head_addr;
      wr_data_d = mem_byp ? mem_data : mem_head_data;
    end else if (alu_gnt) begin
      wr_addr_d = alu_byp ? alu_addr : alu_head_addr;
      wr_data_d = alu_byp ? alu_data : alu_head_data;
    end
  end

  wb_arbiter_fifo #(.AW(AW), .DW(DW)) u_alu_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (alu_push),
    .pop_i       (alu_pop),
    .addr_i      (alu_addr),
    .data_i      (alu_data),
    .full_o      (alu_full),
    .empty_o     (alu_empty),
    .head_addr_o (alu_head_addr),
    .head_data_o (alu_head_data)
  );

  wb_arbiter_fifo #(.AW(AW), .DW(DW)) u_mem_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (mem_push),
    .pop_i       (mem_pop),
    .addr_i      (mem_addr),
    .data_i      (mem_data),
    .full_o      (mem_full),
    .empty_o     (mem_empty),
    .head_addr_o (mem_head_addr),
    .head_data_o (mem_head_data)
  );

  // Registered write port and last-grant memory; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_z_q <= '0;
      data_z_q <= '0;
      last_q   <= GNT_ALU;
    end else begin
      we_q <= wr_en_d;
      if (wr_en_d) begin
        addr_z_q <= wr_addr_d;
        data_z_q <= wr_data_d;
        last_q   <= mem_gnt ? GNT_MEM : GNT_ALU;
      end
    end
  end

  assign write_enable = we_q;
  assign addr_z       = addr_z_q;
  assign data_z       = data_z_q;
endmodule
